// File: rtl/imu_accel_sampler_if.sv
// rtl/imu_accel_sampler_if.sv - I2C master request/response bundle between the sampler and i2c_master
interface imu_accel_sampler_if;
    logic       i2c_start;
    logic       i2c_read_write;
    logic [6:0] i2c_slave_addr;
    logic [6:0] i2c_reg_addr;
    logic [7:0] i2c_data_in;
    logic [7:0] i2c_data_out;
    logic       i2c_busy;
    logic       i2c_done;

    // master: the sequencer issuing transactions
    modport master (
        output i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, i2c_data_in,
        input  i2c_data_out, i2c_busy, i2c_done
    );

    // slave: the i2c_master instance servicing them
    modport slave (
        input  i2c_start, i2c_read_write, i2c_slave_addr, i2c_reg_addr, i2c_data_in,
        output i2c_data_out, i2c_busy, i2c_done
    );
endinterface

// File: rtl/imu_accel_sampler.sv
// rtl/imu_accel_sampler.sv - periodic 6-byte IMU accelerometer reader driving an I2C master
// Optional 4-sample averaging is enabled with `define IMU_ACC_AVG_EN.
module imu_accel_sampler #(
    parameter logic [6:0] IMU_ADDR       = 7'h68,
    parameter logic [6:0] BASE_REG       = 7'h12,
    parameter int         SAMPLE_DIV     = 100000,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    imu_accel_sampler_if.master  bus,
    output logic signed [15:0]   acc_x,
    output logic signed [15:0]   acc_y,
    output logic signed [15:0]   acc_z,
    output logic                 sample_valid,
    output logic                 timeout_err,
    output logic                 overrun
);
    localparam int TW  = $clog2(SAMPLE_DIV);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ASSEMBLE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [TW-1:0]         r_tick_cnt;
    logic [2:0]            r_idx;
    logic [TOW-1:0]        r_to_cnt;
    logic [7:0]            r_buf [0:4];
    logic signed [15:0]    r_acc_x;
    logic signed [15:0]    r_acc_y;
    logic signed [15:0]    r_acc_z;
    logic                  r_sample_valid;

    logic                  w_tick;
    logic                  w_done_ok;
    logic                  w_last;
    logic                  w_to;
    logic                  w_issue;
    logic signed [15:0]    w_smp_x;
    logic signed [15:0]    w_smp_y;
    logic signed [15:0]    w_smp_z;

    assign w_tick    = enable && (r_tick_cnt == TW'(SAMPLE_DIV - 1));
    assign w_done_ok = (r_state == S_WAIT_DONE) && bus.i2c_done;
    assign w_last    = w_done_ok && (r_idx == 3'd5);
    assign w_to      = (r_state == S_WAIT_DONE) && !bus.i2c_done
                       && (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1));
    assign w_issue   = (r_state == S_ISSUE) && !bus.i2c_busy;

    // The final MSB is taken straight from the bus so acc_* land together with sample_valid.
    assign w_smp_x = {r_buf[1], r_buf[0]};
    assign w_smp_y = {r_buf[3], r_buf[2]};
    assign w_smp_z = {bus.i2c_data_out, r_buf[4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_tick) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (!bus.i2c_busy) w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i2c_done) begin
                    w_next = (r_idx == 3'd5) ? S_ASSEMBLE : S_ISSUE;
                end else if (w_to) begin
                    w_next = S_IDLE;
                end
            end
            S_ASSEMBLE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.i2c_start      = !rst && w_issue;
        bus.i2c_read_write = 1'b1;
        bus.i2c_slave_addr = IMU_ADDR;
        bus.i2c_reg_addr   = BASE_REG + {4'd0, r_idx};
        bus.i2c_data_in    = 8'h00;
        timeout_err        = !rst && w_to;
        overrun            = !rst && w_tick && (r_state != S_IDLE);
        sample_valid       = r_sample_valid;
        acc_x              = r_acc_x;
        acc_y              = r_acc_y;
        acc_z              = r_acc_z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && w_tick) begin
                r_idx <= '0;
            end else if (w_done_ok && r_idx != 3'd5) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_issue) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + TOW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_done_ok && r_idx != 3'd5) begin
            r_buf[r_idx] <= bus.i2c_data_out;
        end
    end

`ifdef IMU_ACC_AVG_EN
    logic signed [17:0] r_sum_x;
    logic signed [17:0] r_sum_y;
    logic signed [17:0] r_sum_z;
    logic [1:0]         r_avg_cnt;
    logic signed [17:0] w_nsum_x;
    logic signed [17:0] w_nsum_y;
    logic signed [17:0] w_nsum_z;

    assign w_nsum_x = r_sum_x + {{2{w_smp_x[15]}}, w_smp_x};
    assign w_nsum_y = r_sum_y + {{2{w_smp_y[15]}}, w_smp_y};
    assign w_nsum_z = r_sum_z + {{2{w_smp_z[15]}}, w_smp_z};

    // Taking bits [17:2] is an arithmetic shift right by two (rounds toward -inf).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            r_acc_z        <= '0;
            r_sample_valid <= 1'b0;
            r_sum_x        <= '0;
            r_sum_y        <= '0;
            r_sum_z        <= '0;
            r_avg_cnt      <= '0;
        end else begin
            r_sample_valid <= 1'b0;
            if (w_to) begin
                r_sum_x   <= '0;
                r_sum_y   <= '0;
                r_sum_z   <= '0;
                r_avg_cnt <= '0;
            end else if (w_last) begin
                if (r_avg_cnt == 2'd3) begin
                    r_acc_x        <= w_nsum_x[17:2];
                    r_acc_y        <= w_nsum_y[17:2];
                    r_acc_z        <= w_nsum_z[17:2];
                    r_sample_valid <= 1'b1;
                    r_sum_x        <= '0;
                    r_sum_y        <= '0;
                    r_sum_z        <= '0;
                    r_avg_cnt      <= '0;
                end else begin
                    r_sum_x   <= w_nsum_x;
                    r_sum_y   <= w_nsum_y;
                    r_sum_z   <= w_nsum_z;
                    r_avg_cnt <= r_avg_cnt + 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x        <= '0;
            r_acc_y        <= '0;
            r_acc_z        <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_last;
            if (w_last) begin
                r_acc_x <= w_smp_x;
                r_acc_y <= w_smp_y;
                r_acc_z <= w_smp_z;
            end
        end
    end
`endif
endmodule

// File: tb/tb_imu_accel_sampler.sv
// tb/tb_imu_accel_sampler.sv - scoreboard bench for imu_accel_sampler with a behavioural I2C master
module tb_imu_accel_sampler;
    logic clk;
    logic rst;
    logic enable;
    logic busy;
    logic m_done, s_done;
    logic [7:0] m_data, s_data;
    logic signed [15:0] acc_x, acc_y, acc_z;
    logic sample_valid, timeout_err, overrun;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int n_start = 0, n_valid = 0, n_timeout = 0, n_overrun = 0, n_done = 0;
    int first_start_cyc = -1, last_start_cyc = 0, last_done_cyc = 0;
    int last_valid_cyc = 0, last_timeout_cyc = 0;
    int m_lat = 2;
    int m_drop = -1;
    logic [7:0] m_bytes [6];
    logic [6:0]  exp_addr_q [$];
    logic [47:0] exp_smp_q [$];
    logic prev_start = 1'b0;

    imu_accel_sampler_if bus ();

    assign bus.i2c_busy     = busy;
    assign bus.i2c_done     = m_done | s_done;
    assign bus.i2c_data_out = s_done ? s_data : m_data;

    imu_accel_sampler #(
        .IMU_ADDR(7'h68),
        .BASE_REG(7'h12),
        .SAMPLE_DIV(64),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus),
        .acc_x(acc_x),
        .acc_y(acc_y),
        .acc_z(acc_z),
        .sample_valid(sample_valid),
        .timeout_err(timeout_err),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0: return n_start;
            1: return n_valid;
            2: return n_timeout;
            3: return n_overrun;
            default: return n_done;
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, input string name);
        int b;
        b = budget;
        while (cnt_of(which) < target && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (cnt_of(which) < target) begin
            total++;
            bad++;
            $display("FAIL %s: wait expired, count %0d expected %0d", name, cnt_of(which), target);
        end
    endtask

    task automatic set_bytes(input logic [47:0] v);
        for (int i = 0; i < 6; i++) m_bytes[i] = v[8*i +: 8];
    endtask

    task automatic push_addrs(input int n);
        for (int i = 0; i < n; i++) exp_addr_q.push_back(7'h12 + 7'(i));
    endtask

    // Behavioural i2c_master: answers each start after m_lat cycles unless the byte is dropped.
    always begin
        int idx;
        @(negedge clk);
        if (bus.i2c_start) begin
            idx = int'(bus.i2c_reg_addr) - 'h12;
            if (idx >= 0 && idx < 6 && idx != m_drop) begin
                repeat (m_lat) @(posedge clk);
                #1;
                m_data = m_bytes[idx];
                m_done = 1'b1;
                @(posedge clk);
                #1 m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.i2c_start) begin
            if (first_start_cyc < 0) first_start_cyc = cyc;
            last_start_cyc = cyc;
            n_start++;
            chk("start_gap", {47'd0, prev_start}, 48'd0);
            chk("start_busy", {47'd0, busy}, 48'd0);
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: got reg %0h expected none", bus.i2c_reg_addr);
            end else begin
                chk("reg_addr", {41'd0, bus.i2c_reg_addr}, {41'd0, exp_addr_q.pop_front()});
            end
        end
        prev_start = bus.i2c_start;
        if (bus.i2c_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
        if (timeout_err) begin
            n_timeout++;
            last_timeout_cyc = cyc;
        end
        if (overrun) n_overrun++;
        if (sample_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (exp_smp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %0h expected none", {acc_z, acc_y, acc_x});
            end else begin
                chk("sample", {acc_z, acc_y, acc_x}, exp_smp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cyc, s0, v0, o0, t0, d0;
        rst = 1'b1; enable = 1'b0; busy = 1'b0;
        m_done = 1'b0; s_done = 1'b0; m_data = 8'h00; s_data = 8'h00;
        set_bytes(48'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {44'd0, bus.i2c_start, sample_valid, timeout_err, overrun}, 48'd0);
        chk("rst_reg_addr", {41'd0, bus.i2c_reg_addr}, 48'h12);
        chk("rst_acc", {acc_z, acc_y, acc_x}, 48'd0);
        chk("slave_addr_rw", {40'd0, bus.i2c_read_write, bus.i2c_slave_addr}, 48'hE8);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef IMU_ACC_AVG_EN
        d0 = n_done;
        v0 = n_valid;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_bytes(48'h0000_0000_0064);
                1: set_bytes(48'h0000_0000_0065);
                2: set_bytes(48'h0000_0000_FFFD);
                default: set_bytes(48'h0000_0000_0006);
            endcase
            push_addrs(6);
            if (k == 3) exp_smp_q.push_back(48'h0000_0000_0033);
            if (k == 0) begin
                @(posedge clk);
                #1 enable = 1'b1;
            end
            wait_cnt(4, d0 + 6 * (k + 1), 200, "avg_sample_done");
        end
        repeat (3) @(negedge clk);
        chk("avg_valid_count", 48'(n_valid - v0), 48'd1);
        @(posedge clk);
        #1 enable = 1'b0;
`else
        // Nominal sample, first start 64 cycles after enable
        set_bytes(48'h8000_ABCD_1234);
        push_addrs(6);
        exp_smp_q.push_back(48'h8000_ABCD_1234);
        @(posedge clk);
        #1 enable = 1'b1;
        en_cyc = cyc;
        wait_cnt(1, 1, 300, "t1_valid");
        @(posedge clk);
        #1 enable = 1'b0;
        chk("first_start_cycle", 48'(first_start_cyc - en_cyc), 48'd64);
        chk("valid_latency", 48'(last_valid_cyc - last_done_cyc), 48'd1);
        chk("t1_starts", 48'(n_start), 48'd6);

        // Busy held at ISSUE
        set_bytes(48'h0605_0403_0201);
        push_addrs(6);
        exp_smp_q.push_back(48'h0605_0403_0201);
        busy = 1'b1;
        s0 = n_start;
        v0 = n_valid;
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (84) @(posedge clk);
        #1;
        chk("busy_no_start", 48'(n_start - s0), 48'd0);
        busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("busy_one_start", 48'(n_start - s0), 48'd1);
        wait_cnt(1, v0 + 1, 300, "t2_valid");
        @(posedge clk);
        #1 enable = 1'b0;

        // Byte 3 never completes
        set_bytes(48'h6655_4433_2211);
        m_drop = 3;
        push_addrs(4);
        push_addrs(6);
        exp_smp_q.push_back(48'h6655_4433_2211);
        t0 = n_timeout;
        o0 = n_overrun;
        v0 = n_valid;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_cnt(2, t0 + 1, 400, "t3_timeout");
        chk("timeout_delay", 48'(last_timeout_cyc - last_start_cyc), 48'd100);
        @(negedge clk);
        chk("acc_kept", {acc_z, acc_y, acc_x}, 48'h0605_0403_0201);
        chk("t3_overrun", 48'(n_overrun - o0), 48'd1);
        m_drop = -1;
        wait_cnt(1, v0 + 1, 300, "t3_valid");
        @(posedge clk);
        #1 enable = 1'b0;

        // Slow master: tick lands mid-sample
        m_lat = 20;
        set_bytes(48'hA6A5_A4A3_A2A1);
        push_addrs(6);
        exp_smp_q.push_back(48'hA6A5_A4A3_A2A1);
        s0 = n_start;
        o0 = n_overrun;
        v0 = n_valid;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_cnt(3, o0 + 1, 300, "t4_overrun");
        @(posedge clk);
        #1 enable = 1'b0;
        wait_cnt(1, v0 + 1, 300, "t4_valid");
        repeat (70) @(negedge clk);
        chk("t4_starts", 48'(n_start - s0), 48'd6);
        chk("t4_overruns", 48'(n_overrun - o0), 48'd1);

        // Reset during WAIT_DONE of byte 2
        m_lat = 2;
        m_drop = 2;
        set_bytes(48'h0000_0000_7777);
        push_addrs(3);
        s0 = n_start;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_cnt(0, s0 + 3, 200, "t5_starts");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {44'd0, bus.i2c_start, sample_valid, timeout_err, overrun}, 48'd0);
        chk("rst_mid_reg_addr", {41'd0, bus.i2c_reg_addr}, 48'h12);
        chk("rst_mid_acc", {acc_z, acc_y, acc_x}, 48'd0);
        s0 = n_start;
        v0 = n_valid;
        @(posedge clk);
        #1 s_data = 8'hFF;
        s_done = 1'b1;
        @(posedge clk);
        #1 s_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("stray_done_no_valid", 48'(n_valid - v0), 48'd0);
        chk("stray_done_no_start", 48'(n_start - s0), 48'd0);
        chk("stray_done_acc", {acc_z, acc_y, acc_x}, 48'd0);
`endif
        chk("addr_queue_empty", 48'(exp_addr_q.size()), 48'd0);
        chk("sample_queue_empty", 48'(exp_smp_q.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
